// File: rtl/exa_crosb_cfg_arb.sv
// Round-robin arbiter that serialises N req/ack register requesters onto a single AXI4 master port.
// Single-beat transactions, one outstanding at a time, with a per-state watchdog abort.
module exa_crosb_cfg_arb #(
    parameter int REQ_NUM    = 4,
    parameter int IDX_WIDTH  = 4,
    parameter int ID_WIDTH   = 12,
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = IDX_WIDTH + 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                         ACLK,
    input  logic                         ARESET,
    input  logic [REQ_NUM-1:0]           i_req,
    input  logic [REQ_NUM-1:0]           i_we,
    input  logic [REQ_NUM*IDX_WIDTH-1:0] i_idx,
    input  logic [REQ_NUM*64-1:0]        i_wdata,
    output logic [REQ_NUM-1:0]           o_ack,
    output logic [63:0]                  o_rdata,
    output logic                         o_err,
    output logic [ID_WIDTH-1:0]          M_AXI_AWID,
    output logic [ADDR_WIDTH-1:0]        M_AXI_AWADDR,
    output logic [7:0]                   M_AXI_AWLEN,
    output logic [2:0]                   M_AXI_AWSIZE,
    output logic [1:0]                   M_AXI_AWBURST,
    output logic                         M_AXI_AWVALID,
    input  logic                         M_AXI_AWREADY,
    output logic [DATA_WIDTH-1:0]        M_AXI_WDATA,
    output logic [DATA_WIDTH/8-1:0]      M_AXI_WSTRB,
    output logic                         M_AXI_WLAST,
    output logic                         M_AXI_WVALID,
    input  logic                         M_AXI_WREADY,
    input  logic [ID_WIDTH-1:0]          M_AXI_BID,
    input  logic [1:0]                   M_AXI_BRESP,
    input  logic                         M_AXI_BVALID,
    output logic                         M_AXI_BREADY,
    output logic [ID_WIDTH-1:0]          M_AXI_ARID,
    output logic [ADDR_WIDTH-1:0]        M_AXI_ARADDR,
    output logic [7:0]                   M_AXI_ARLEN,
    output logic [2:0]                   M_AXI_ARSIZE,
    output logic [1:0]                   M_AXI_ARBURST,
    output logic                         M_AXI_ARVALID,
    input  logic                         M_AXI_ARREADY,
    input  logic [ID_WIDTH-1:0]          M_AXI_RID,
    input  logic [DATA_WIDTH-1:0]        M_AXI_RDATA,
    input  logic [1:0]                   M_AXI_RRESP,
    input  logic                         M_AXI_RLAST,
    input  logic                         M_AXI_RVALID,
    output logic                         M_AXI_RREADY
);

    localparam int GW = $clog2(REQ_NUM);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_AR, S_R, S_DONE} state_t;

    state_t                 state_q, state_d;
    logic [GW-1:0]          rr_q, rr_d;
    logic [GW-1:0]          gnt_q, gnt_d;
    logic                   we_q, we_d;
    logic [IDX_WIDTH-1:0]   idx_q, idx_d;
    logic [63:0]            wdata_q, wdata_d;
    logic                   err_q, err_d;
    logic [63:0]            rdata_q, rdata_d;
    logic [CW-1:0]          cnt_q, cnt_d;

    logic                   req_any;
    logic [GW-1:0]          pick;
    logic                   tmo;
    logic                   wait_st;

    // IDs and upper read-data lanes are not needed with a single outstanding transaction.
    logic unused_ok;
    assign unused_ok = ^{M_AXI_BID, M_AXI_RID, M_AXI_RDATA[DATA_WIDTH-1:64]};

    assign req_any = |i_req;
    assign tmo     = (cnt_q == CW'(TIMEOUT));
    assign wait_st = (state_q == S_AW) || (state_q == S_W) || (state_q == S_B) ||
                     (state_q == S_AR) || (state_q == S_R);

    // Search starts one past the last grant so the previous winner has lowest priority.
    always_comb begin
        logic [GW:0] slot;
        logic        found;
        pick  = rr_q;
        found = 1'b0;
        slot  = '0;
        for (int i = 1; i <= REQ_NUM; i++) begin
            slot = {1'b0, rr_q} + (GW+1)'(i);
            if (slot >= (GW+1)'(REQ_NUM)) slot = slot - (GW+1)'(REQ_NUM);
            if (!found && i_req[slot[GW-1:0]]) begin
                found = 1'b1;
                pick  = slot[GW-1:0];
            end
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (req_any) state_d = i_we[pick] ? S_AW : S_AR;
            S_AW:   if (tmo) state_d = S_DONE; else if (M_AXI_AWREADY) state_d = S_W;
            S_W:    if (tmo) state_d = S_DONE; else if (M_AXI_WREADY)  state_d = S_B;
            S_B:    if (tmo || M_AXI_BVALID) state_d = S_DONE;
            S_AR:   if (tmo) state_d = S_DONE; else if (M_AXI_ARREADY) state_d = S_R;
            S_R:    if (tmo || M_AXI_RVALID) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake outputs are masked in the expiry cycle so no transfer can race the abort.
    always_comb begin
        M_AXI_AWVALID = (state_q == S_AW) && !tmo;
        M_AXI_WVALID  = (state_q == S_W)  && !tmo;
        M_AXI_BREADY  = (state_q == S_B)  && !tmo;
        M_AXI_ARVALID = (state_q == S_AR) && !tmo;
        M_AXI_RREADY  = (state_q == S_R)  && !tmo;
        o_ack         = (state_q == S_DONE) ? (REQ_NUM'(1) << gnt_q) : '0;
        o_err         = (state_q == S_DONE) && err_q;
    end

    always_comb begin
        rr_d    = rr_q;
        gnt_d   = gnt_q;
        we_d    = we_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (req_any) begin
                    rr_d    = pick;
                    gnt_d   = pick;
                    we_d    = i_we[pick];
                    idx_d   = i_idx[int'(pick)*IDX_WIDTH +: IDX_WIDTH];
                    wdata_d = i_wdata[int'(pick)*64 +: 64];
                    err_d   = 1'b0;
                end
            end
            S_AW, S_W: if (tmo) err_d = 1'b1;
            S_B: begin
                if (tmo)               err_d = 1'b1;
                else if (M_AXI_BVALID) err_d = (M_AXI_BRESP != 2'b00);
            end
            S_AR: begin
                if (tmo) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                end
            end
            S_R: begin
                if (tmo) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                end else if (M_AXI_RVALID) begin
                    rdata_d = M_AXI_RDATA[63:0];
                    err_d   = (M_AXI_RRESP != 2'b00) || !M_AXI_RLAST;
                end
            end
            default: ;
        endcase
        cnt_d = (wait_st && (state_d == state_q)) ? cnt_q + CW'(1) : '0;
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            rr_q    <= GW'(REQ_NUM - 1);
            gnt_q   <= '0;
            we_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            rr_q    <= rr_d;
            gnt_q   <= gnt_d;
            we_q    <= we_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_rdata       = rdata_q;
    assign M_AXI_AWID    = ID_WIDTH'(gnt_q);
    assign M_AXI_ARID    = ID_WIDTH'(gnt_q);
    assign M_AXI_AWADDR  = ADDR_WIDTH'({idx_q, 4'b0000});
    assign M_AXI_ARADDR  = ADDR_WIDTH'({idx_q, 4'b0000});
    assign M_AXI_WDATA   = DATA_WIDTH'({wdata_q, wdata_q});
    assign M_AXI_WSTRB   = (DATA_WIDTH/8)'(16'h00FF);
    assign M_AXI_WLAST   = 1'b1;
    assign M_AXI_AWLEN   = 8'd0;
    assign M_AXI_AWSIZE  = 3'b100;
    assign M_AXI_AWBURST = 2'b01;
    assign M_AXI_ARLEN   = 8'd0;
    assign M_AXI_ARSIZE  = 3'b100;
    assign M_AXI_ARBURST = 2'b01;

endmodule

// File: tb/tb_exa_crosb_cfg_arb.sv
// Directed bench for exa_crosb_cfg_arb: latency, addressing, round-robin order, error paths, watchdog and reset abort.
module tb_exa_crosb_cfg_arb;
    localparam int N = 4;

    logic            ACLK = 1'b0;
    logic            ARESET;
    logic [N-1:0]    i_req, i_we;
    logic [N*4-1:0]  i_idx;
    logic [N*64-1:0] i_wdata;
    logic [N-1:0]    o_ack;
    logic [63:0]     o_rdata;
    logic            o_err;
    logic [11:0]     awid, arid, bid, rid;
    logic [7:0]      awaddr, araddr, awlen, arlen;
    logic [2:0]      awsize, arsize;
    logic [1:0]      awburst, arburst, bresp, rresp;
    logic            awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic            arvalid, arready, rvalid, rready, rlast;
    logic [127:0]    wdata, rdata;
    logic [15:0]     wstrb;

    exa_crosb_cfg_arb dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .i_req(i_req), .i_we(i_we), .i_idx(i_idx), .i_wdata(i_wdata),
        .o_ack(o_ack), .o_rdata(o_rdata), .o_err(o_err),
        .M_AXI_AWID(awid), .M_AXI_AWADDR(awaddr), .M_AXI_AWLEN(awlen), .M_AXI_AWSIZE(awsize),
        .M_AXI_AWBURST(awburst), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
        .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WLAST(wlast), .M_AXI_WVALID(wvalid),
        .M_AXI_WREADY(wready),
        .M_AXI_BID(bid), .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
        .M_AXI_ARID(arid), .M_AXI_ARADDR(araddr), .M_AXI_ARLEN(arlen), .M_AXI_ARSIZE(arsize),
        .M_AXI_ARBURST(arburst), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
        .M_AXI_RID(rid), .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RLAST(rlast),
        .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
    );

    always #5 ACLK = ~ACLK;

    int pass_cnt = 0;
    int total    = 0;

    logic [7:0]   cap_awaddr, cap_araddr;
    logic [11:0]  cap_awid, cap_arid;
    logic [127:0] cap_wdata;
    logic [15:0]  cap_wstrb;
    logic         cap_wlast, overlap;
    int           awv_cycles, lat;
    logic [N-1:0] ack_seen;
    logic         err_seen;
    logic [63:0]  rdata_seen;

    task automatic do_reset();
        ARESET = 1'b1;
        i_req  = '0;
        repeat (2) @(negedge ACLK);
        ARESET = 1'b0;
    endtask

    // Issues one request from requester k in the next IDLE cycle and watches the bus until its ack.
    task automatic run_txn(input int k, input logic we, input logic [3:0] idx,
                           input logic [63:0] wd, input int max_cyc);
        logic done;
        @(negedge ACLK);
        cap_awaddr = 'x; cap_araddr = 'x; cap_awid = 'x; cap_arid = 'x;
        cap_wdata = 'x; cap_wstrb = 'x; cap_wlast = 1'bx;
        overlap = 1'b0; awv_cycles = 0; lat = 0; ack_seen = '0; err_seen = 1'bx; rdata_seen = 'x;
        done = 1'b0;
        i_we[k] = we;
        i_idx[k*4 +: 4] = idx;
        i_wdata[k*64 +: 64] = wd;
        i_req[k] = 1'b1;
        for (int c = 2; c <= max_cyc && !done; c++) begin
            @(negedge ACLK);
            if (awvalid) begin cap_awaddr = awaddr; cap_awid = awid; awv_cycles++; end
            if (wvalid)  begin cap_wdata = wdata; cap_wstrb = wstrb; cap_wlast = wlast; end
            if (arvalid) begin cap_araddr = araddr; cap_arid = arid; end
            if (awvalid && wvalid) overlap = 1'b1;
            if (o_ack != '0) begin
                lat = c; ack_seen = o_ack; err_seen = o_err; rdata_seen = o_rdata; done = 1'b1;
            end
        end
        i_req[k] = 1'b0;
        if (!done) begin
            total++;
            $display("FAIL txn_wait: no ack from requester %0d within %0d cycles", k, max_cyc);
        end
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (o_ack !== 4'b0000) $display("FAIL rst_ack: got %b want 0000", o_ack); else pass_cnt++;
        total++; if (o_err !== 1'b0) $display("FAIL rst_err: got %b want 0", o_err); else pass_cnt++;
        total++; if (o_rdata !== 64'd0) $display("FAIL rst_rdata: got %h want 0", o_rdata); else pass_cnt++;
        total++;
        if ({awvalid, wvalid, bready, arvalid, rready} !== 5'b00000)
            $display("FAIL rst_handshake: got %b want 00000", {awvalid, wvalid, bready, arvalid, rready});
        else pass_cnt++;
    endtask

    task automatic test_write();
        run_txn(2, 1'b1, 4'd1, 64'h0000_0000_0012_3456, 20);
        total++; if (ack_seen !== 4'b0100) $display("FAIL wr_ack: got %b want 0100", ack_seen); else pass_cnt++;
        total++; if (lat !== 5) $display("FAIL wr_latency: got %0d want 5", lat); else pass_cnt++;
        total++; if (err_seen !== 1'b0) $display("FAIL wr_err: got %b want 0", err_seen); else pass_cnt++;
        total++; if (cap_awaddr !== 8'h10) $display("FAIL wr_awaddr: got %h want 10", cap_awaddr); else pass_cnt++;
        total++; if (cap_awid !== 12'd2) $display("FAIL wr_awid: got %h want 002", cap_awid); else pass_cnt++;
        total++; if (cap_wstrb !== 16'h00FF) $display("FAIL wr_wstrb: got %h want 00ff", cap_wstrb); else pass_cnt++;
        total++;
        if (cap_wdata !== {64'h0000_0000_0012_3456, 64'h0000_0000_0012_3456})
            $display("FAIL wr_wdata: got %h want 123456 in both halves", cap_wdata);
        else pass_cnt++;
        total++; if (cap_wlast !== 1'b1) $display("FAIL wr_wlast: got %b want 1", cap_wlast); else pass_cnt++;
        total++; if (overlap !== 1'b0) $display("FAIL wr_aw_w_overlap: got %b want 0", overlap); else pass_cnt++;
        total++;
        if ({awlen, awsize, awburst} !== {8'd0, 3'b100, 2'b01})
            $display("FAIL wr_burst_consts: got %h want %h", {awlen, awsize, awburst}, {8'd0, 3'b100, 2'b01});
        else pass_cnt++;
    endtask

    task automatic test_read();
        run_txn(0, 1'b0, 4'd3, 64'd0, 20);
        total++; if (ack_seen !== 4'b0001) $display("FAIL rd_ack: got %b want 0001", ack_seen); else pass_cnt++;
        total++; if (lat !== 4) $display("FAIL rd_latency: got %0d want 4", lat); else pass_cnt++;
        total++; if (cap_araddr !== 8'h30) $display("FAIL rd_araddr: got %h want 30", cap_araddr); else pass_cnt++;
        total++; if (cap_arid !== 12'd0) $display("FAIL rd_arid: got %h want 000", cap_arid); else pass_cnt++;
        total++;
        if (rdata_seen !== 64'hDEAD_BEEF_0000_0001)
            $display("FAIL rd_rdata: got %h want deadbeef00000001", rdata_seen);
        else pass_cnt++;
        total++; if (err_seen !== 1'b0) $display("FAIL rd_err: got %b want 0", err_seen); else pass_cnt++;
        @(negedge ACLK);
        total++;
        if (o_rdata !== 64'hDEAD_BEEF_0000_0001) $display("FAIL rd_hold: got %h want deadbeef00000001", o_rdata);
        else pass_cnt++;
    endtask

    task automatic test_fairness();
        int order[5];
        int n = 0;
        int wide = 0;
        logic [N-1:0] prev = '0;
        do_reset();
        i_we  = '0;
        i_req = 4'hF;
        for (int c = 0; c < 100 && n < 5; c++) begin
            @(negedge ACLK);
            if (o_ack != '0 && prev != '0) wide++;
            if (o_ack != '0) begin
                for (int j = 0; j < N; j++) if (o_ack[j]) order[n] = j;
                n++;
            end
            prev = o_ack;
        end
        @(negedge ACLK);
        if (o_ack != '0 && prev != '0) wide++;
        i_req = '0;
        total++; if (n !== 5) $display("FAIL rr_count: got %0d acks want 5", n); else pass_cnt++;
        for (int j = 0; j < 5; j++) begin
            total++;
            if (j < n && order[j] == j % N) pass_cnt++;
            else $display("FAIL rr_order[%0d]: got %0d want %0d", j, (j < n) ? order[j] : -1, j % N);
        end
        total++; if (wide !== 0) $display("FAIL rr_ack_width: got %0d multi-cycle acks want 0", wide); else pass_cnt++;
    endtask

    task automatic test_bresp_err();
        bresp = 2'b11;
        run_txn(1, 1'b1, 4'd5, 64'h55, 20);
        bresp = 2'b00;
        total++; if (ack_seen !== 4'b0010) $display("FAIL bresp_ack: got %b want 0010", ack_seen); else pass_cnt++;
        total++; if (err_seen !== 1'b1) $display("FAIL bresp_err: got %b want 1", err_seen); else pass_cnt++;
    endtask

    task automatic test_timeout();
        awready = 1'b0;
        run_txn(3, 1'b1, 4'd2, 64'h77, 400);
        awready = 1'b1;
        total++; if (awv_cycles !== 255) $display("FAIL tmo_awvalid_cycles: got %0d want 255", awv_cycles); else pass_cnt++;
        total++; if (ack_seen !== 4'b1000) $display("FAIL tmo_ack: got %b want 1000", ack_seen); else pass_cnt++;
        total++; if (err_seen !== 1'b1) $display("FAIL tmo_err: got %b want 1", err_seen); else pass_cnt++;
        total++; if (lat !== 258) $display("FAIL tmo_latency: got %0d want 258", lat); else pass_cnt++;
        run_txn(1, 1'b0, 4'd2, 64'd0, 20);
        total++; if (ack_seen !== 4'b0010) $display("FAIL tmo_next_ack: got %b want 0010", ack_seen); else pass_cnt++;
        total++; if (err_seen !== 1'b0) $display("FAIL tmo_next_err: got %b want 0", err_seen); else pass_cnt++;
        rvalid = 1'b0;
        run_txn(0, 1'b0, 4'd4, 64'd0, 400);
        rvalid = 1'b1;
        total++; if (err_seen !== 1'b1) $display("FAIL tmo_rd_err: got %b want 1", err_seen); else pass_cnt++;
        total++; if (rdata_seen !== 64'd0) $display("FAIL tmo_rd_rdata: got %h want 0", rdata_seen); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        logic in_b = 1'b0;
        logic any_ack = 1'b0;
        logic [N-1:0] got = '0;
        bvalid = 1'b0;
        @(negedge ACLK);
        i_we[1] = 1'b1;
        i_idx[4 +: 4] = 4'd7;
        i_req[1] = 1'b1;
        for (int c = 0; c < 20 && !in_b; c++) begin
            @(negedge ACLK);
            if (bready) in_b = 1'b1;
        end
        total++; if (in_b !== 1'b1) $display("FAIL mid_reach_b: got %b want 1", in_b); else pass_cnt++;
        ARESET = 1'b1;
        #1;
        total++; if (bready !== 1'b0) $display("FAIL mid_bready: got %b want 0", bready); else pass_cnt++;
        i_req = '0;
        repeat (3) begin
            @(negedge ACLK);
            if (o_ack != '0) any_ack = 1'b1;
        end
        ARESET = 1'b0;
        bvalid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge ACLK);
            if (o_ack != '0) any_ack = 1'b1;
        end
        total++; if (any_ack !== 1'b0) $display("FAIL mid_no_ack: got %b want 0", any_ack); else pass_cnt++;
        i_we  = '0;
        i_req = 4'b1001;
        for (int c = 0; c < 20 && got == '0; c++) begin
            @(negedge ACLK);
            got = o_ack;
        end
        i_req = '0;
        total++; if (got !== 4'b0001) $display("FAIL mid_next_grant: got %b want 0001", got); else pass_cnt++;
    endtask

    initial begin
        i_req = '0; i_we = '0; i_idx = '0; i_wdata = '0;
        awready = 1'b1; wready = 1'b1; arready = 1'b1;
        bvalid = 1'b1; bresp = 2'b00; bid = '0;
        rvalid = 1'b1; rresp = 2'b00; rlast = 1'b1; rid = '0;
        rdata = {64'hFFFF_FFFF_FFFF_FFFF, 64'hDEAD_BEEF_0000_0001};
        ARESET = 1'b1;
        @(negedge ACLK);
        test_reset();
        test_write();
        test_read();
        test_fairness();
        test_bresp_err();
        test_timeout();
        test_reset_mid();
        repeat (3) @(negedge ACLK);
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
